// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU,
//   DIV and DIVU one radix-2 step per clock and writes the architectural
//   HI/LO registers. MTHI/MTLO writes are accepted only while idle.
//
//   Ports
//     clock        : single clock, all state changes on posedge
//     reset        : synchronous, active-high; aborts any operation
//     start        : operation request, sampled only in IDLE
//     op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     inA / inB    : multiplicand/dividend, multiplier/divisor
//     hi_wen/lo_wen: MTHI/MTLO write enables, data on wd
//     busy         : operation in progress
//     done         : one-cycle pulse when HI/LO were written by an operation
//     div_by_zero  : divisor was zero; updated with done, held until next start
//     hi / lo      : HI and LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int N = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] inA,
   input  logic [N-1:0] inB,
   input  logic         hi_wen,
   input  logic         lo_wen,
   input  logic [N-1:0] wd,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_div_q, is_div_d;
   logic          divz_q, divz_d;     // divisor was zero at issue
   logic          neg_q, neg_d;       // product / quotient must be negated
   logic          rneg_q, rneg_d;     // remainder must be negated
   logic [N-1:0]  opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [N-1:0]  p_hi_q, p_hi_d;     // product high half / partial remainder
   logic [N-1:0]  p_lo_q, p_lo_d;     // multiplier bits / dividend->quotient
   logic [N-1:0]  hi_q, hi_d;
   logic [N-1:0]  lo_q, lo_d;
   logic          done_q, done_d;
   logic          dbz_q, dbz_d;

   logic          sgn_op;
   logic [N-1:0]  a_mag, b_mag;
   logic [N:0]    mul_sum;
   logic [N:0]    div_trial;
   logic [2*N-1:0] prod;

   // Signed ops work on magnitudes; the signs are reapplied in FIX.
   assign sgn_op = ~op[0];
   assign a_mag  = (sgn_op && inA[N-1]) ? -inA : inA;
   assign b_mag  = (sgn_op && inB[N-1]) ? -inB : inB;

   // Multiply step: conditionally add the multiplicand into the upper half,
   // then shift the whole product right; the carry lands in bit N-1.
   assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});

   // Divide step: shift the next dividend bit into the partial remainder and
   // try subtracting the divisor; bit N set means the subtraction borrowed.
   // With a zero divisor the remainder simply collects the dividend.
   assign div_trial = {p_hi_q, p_lo_q[N-1]} - {1'b0, opnd_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      divz_d   = divz_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      opnd_d   = opnd_q;
      p_hi_d   = p_hi_q;
      p_lo_d   = p_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      prod     = {p_hi_q, p_lo_q};

      case (state_q)
         IDLE: begin
            if (hi_wen) hi_d = wd;
            if (lo_wen) lo_d = wd;
            if (start) begin
               state_d  = CALC;
               cnt_d    = '0;
               is_div_d = op[1];
               divz_d   = op[1] && (inB == '0);
               neg_d    = sgn_op && (inA[N-1] ^ inB[N-1]);
               rneg_d   = sgn_op && op[1] && inA[N-1];
               dbz_d    = 1'b0;
               p_hi_d   = '0;
               if (op[1]) begin
                  opnd_d = b_mag;
                  p_lo_d = a_mag;
               end else begin
                  opnd_d = a_mag;
                  p_lo_d = b_mag;
               end
            end
         end

         CALC: begin
            if (is_div_q) begin
               if (!div_trial[N]) begin
                  p_hi_d = div_trial[N-1:0];
                  p_lo_d = {p_lo_q[N-2:0], 1'b1};
               end else begin
                  p_hi_d = {p_hi_q[N-2:0], p_lo_q[N-1]};
                  p_lo_d = {p_lo_q[N-2:0], 1'b0};
               end
            end else begin
               {p_hi_d, p_lo_d} = {mul_sum, p_lo_q[N-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = FIX;
         end

         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            dbz_d   = divz_q;
            if (is_div_q) begin
               // Remainder keeps the dividend's sign; for a zero divisor the
               // remainder magnitude is |inA|, so this restores inA exactly.
               hi_d = rneg_q ? -p_hi_q : p_hi_q;
               if (divz_q) lo_d = '1;
               else        lo_d = neg_q ? -p_lo_q : p_lo_q;
            end else begin
               if (neg_q) prod = -{p_hi_q, p_lo_q};
               {hi_d, lo_d} = prod;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         divz_q   <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         opnd_q   <= '0;
         p_hi_q   <= '0;
         p_lo_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         divz_q   <= divz_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         opnd_q   <= opnd_d;
         p_hi_q   <= p_hi_d;
         p_lo_q   <= p_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: directed vector table, random
//   operations against an arithmetic reference model, and hand sequences for
//   overlap, MTHI/MTLO and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int N   = 32;
   localparam int LAT = N + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op    = 2'b00;
   logic [N-1:0]  inA   = '0;
   logic [N-1:0]  inB   = '0;
   logic          hi_wen = 1'b0;
   logic          lo_wen = 1'b0;
   logic [N-1:0]  wd    = '0;
   logic          busy, done, div_by_zero;
   logic [N-1:0]  hi, lo;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.N(N)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .inA         (inA),
      .inB         (inB),
      .hi_wen      (hi_wen),
      .lo_wen      (lo_wen),
      .wd          (wd),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model straight from the ISA definition: returns {dbz, hi, lo}.
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint            sp;
      longint unsigned   up;
      int                sa, sb, q, r;
      logic [64:0]       res;
      res = '0;
      case (o)
         2'b00: begin
            sp  = longint'($signed(a)) * longint'($signed(b));
            res = {1'b0, sp[63:0]};
         end
         2'b01: begin
            up  = longint'({32'b0, a}) * longint'({32'b0, b});
            res = {1'b0, up[63:0]};
         end
         2'b10: begin
            if (b == 0)                                   res = {1'b1, a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == '1)       res = {1'b0, 32'h0, 32'h8000_0000};
            else begin
               sa = $signed(a); sb = $signed(b);
               q = sa / sb; r = sa % sb;
               res = {1'b0, r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {1'b1, a, 32'hFFFF_FFFF};
            else        res = {1'b0, a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Issue one op and follow it to completion, checking latency, busy length,
   // done pulse width. pulse_at: cycle after E0 at which a stray start is
   // pulsed; wen_at: cycle at which hi_wen(wd=0x1234) is pulsed while busy.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input int wen_at,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rd);
      int          lat, busy_cnt;
      logic [31:0] hi_before;
      @(negedge clock);
      hi_before = hi;
      start = 1'b1; op = o; inA = a; inB = b;
      @(posedge clock); #1;
      start = 1'b0;
      inA = $urandom; inB = $urandom; op = 2'($urandom);   // operands must be latched
      lat = -1; busy_cnt = 0;
      for (int c = 1; c <= LAT + 5; c++) begin
         if (busy) busy_cnt++;
         start  = (c == pulse_at);
         hi_wen = (c == wen_at);
         wd     = 32'h1234;
         if (c == pulse_at) begin op = 2'b10; inA = 32'd77; inB = 32'd3; end
         @(posedge clock); #1;
         start = 1'b0; hi_wen = 1'b0;
         if (c == wen_at) chk("hi_write_while_busy", {32'b0, hi}, {32'b0, hi_before});
         if (done) begin lat = c; break; end
      end
      chk("latency", 64'(lat), 64'(LAT));
      chk("busy_cycles", 64'(busy_cnt), 64'(LAT));
      chk("busy_low_at_done", {63'b0, busy}, 64'd0);
      rh = hi; rl = lo; rd = div_by_zero;
      @(posedge clock); #1;
      chk("done_one_cycle", {63'b0, done}, 64'd0);
      chk("dbz_held", {63'b0, div_by_zero}, {63'b0, rd});
   endtask

   vec_t        vecs[$];
   logic [31:0] rh, rl;
   logic        rd;
   logic [64:0] m;
   int          cnt;

   initial begin
      vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
      vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
      vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0});
      vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
      vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0});
      vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0});
      vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{2'b10, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1});

      // Reset state
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_done", {63'b0, done}, 64'd0);
      chk("reset_dbz",  {63'b0, div_by_zero}, 64'd0);
      chk("reset_hi",   {32'b0, hi}, 64'd0);
      chk("reset_lo",   {32'b0, lo}, 64'd0);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, rh, rl, rd);
         chk("vec_hi",  {32'b0, rh}, {32'b0, vecs[i].exp_hi});
         chk("vec_lo",  {32'b0, rl}, {32'b0, vecs[i].exp_lo});
         chk("vec_dbz", {63'b0, rd}, {63'b0, vecs[i].exp_dbz});
         $display("vec %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rd);
      end

      // Random operations against the model
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         m = model(ro, ra, rb);
         run_op(ro, ra, rb, -1, -1, rh, rl, rd);
         chk("rnd_hi",  {32'b0, rh}, {32'b0, m[63:32]});
         chk("rnd_lo",  {32'b0, rl}, {32'b0, m[31:0]});
         chk("rnd_dbz", {63'b0, rd}, {63'b0, m[64]});
         $display("rnd %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b",
                  i, ro, ra, rb, rh, rl, rd);
      end

      // Stray start while busy is ignored and not queued
      run_op(2'b01, 32'd5, 32'd5, 10, -1, rh, rl, rd);
      chk("overlap_lo", {32'b0, rl}, 64'd25);
      chk("overlap_hi", {32'b0, rh}, 64'd0);
      cnt = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(posedge clock); #1;
         if (done || busy) cnt++;
      end
      chk("overlap_no_second_op", 64'(cnt), 64'd0);
      $display("overlap: lo=0x%08h, extra activity cycles=%0d", rl, cnt);

      // MTHI/MTLO in IDLE, then ignored while busy
      @(negedge clock);
      hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'hAAAA_5555;
      @(posedge clock); #1;
      hi_wen = 1'b0; lo_wen = 1'b0;
      chk("mt_both_hi", {32'b0, hi}, 64'hAAAA_5555);
      chk("mt_both_lo", {32'b0, lo}, 64'hAAAA_5555);
      $display("mthi/mtlo idle: hi=0x%08h lo=0x%08h", hi, lo);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 12, rh, rl, rd);
      chk("wen_busy_result_hi", {32'b0, rh}, 64'hFFFF_FFFF);
      @(negedge clock);
      hi_wen = 1'b1; wd = 32'h1234;
      @(posedge clock); #1;
      hi_wen = 1'b0;
      chk("mthi_idle", {32'b0, hi}, 64'h1234);
      chk("mthi_idle_lo_kept", {32'b0, lo}, 64'hFFFF_FFEB);
      $display("mthi idle: hi=0x%08h lo=0x%08h", hi, lo);

      // Mid-operation reset
      @(negedge clock);
      start = 1'b1; op = 2'b00; inA = 32'hFFFF_FFFD; inB = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (14) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_hi",   {32'b0, hi}, 64'd0);
      chk("midrst_lo",   {32'b0, lo}, 64'd0);
      chk("midrst_done", {63'b0, done}, 64'd0);
      cnt = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(posedge clock); #1;
         if (done) cnt++;
      end
      chk("midrst_no_done", 64'(cnt), 64'd0);
      $display("mid-op reset: busy=%0b hi=0x%08h lo=0x%08h late_done=%0d", busy, hi, lo, cnt);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, rh, rl, rd);
      chk("after_rst_hi", {32'b0, rh}, 64'hFFFF_FFFF);
      chk("after_rst_lo", {32'b0, rl}, 64'hFFFF_FFEB);
      $display("after reset MULT: hi=0x%08h lo=0x%08h", rh, rl);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
